// File: rtl/pipelined_cpu_hz.sv
// Five-stage MIPS-subset core with forwarding, hazard interlocks and branch/jump flush.
// Instruction and data memories are external with combinational read.
module pipelined_cpu_hz #(
  parameter int              XLEN     = 32,
  parameter int              NREG     = 32,
  parameter int              FORWARD  = 1,
  parameter logic [XLEN-1:0] RESET_PC = '0
) (
  input  logic            clk,
  input  logic            reset,
  output logic [XLEN-1:0] imem_addr,
  input  logic [31:0]     imem_rdata,
  output logic [XLEN-1:0] dmem_addr,
  output logic [XLEN-1:0] dmem_wdata,
  output logic            dmem_we,
  output logic            dmem_re,
  input  logic [XLEN-1:0] dmem_rdata,
  output logic            wb_valid,
  output logic [4:0]      wb_rd,
  output logic [XLEN-1:0] wb_data,
  output logic            stall,
  output logic            flush
);
  localparam int RW = (NREG > 1) ? $clog2(NREG) : 1;

  typedef enum logic [2:0] {ALU_ADD, ALU_SUB, ALU_AND, ALU_OR, ALU_SLT, ALU_SLL} alu_op_e;

  logic [XLEN-1:0] pc;

  logic            if_id_valid;
  logic [31:0]     if_id_instr;
  logic [XLEN-1:0] if_id_pc4;

  logic            id_ex_valid, id_ex_reg_write, id_ex_mem_read, id_ex_mem_write;
  logic            id_ex_branch, id_ex_use_imm;
  alu_op_e         id_ex_alu_op;
  logic [RW-1:0]   id_ex_rs, id_ex_rt, id_ex_dest;
  logic [XLEN-1:0] id_ex_a, id_ex_b, id_ex_imm, id_ex_pc4;
  logic [4:0]      id_ex_shamt;

  logic            ex_mem_valid, ex_mem_reg_write, ex_mem_mem_read, ex_mem_mem_write;
  logic [RW-1:0]   ex_mem_dest;
  logic [XLEN-1:0] ex_mem_alu, ex_mem_store;

  logic            mem_wb_valid, mem_wb_reg_write;
  logic [RW-1:0]   mem_wb_dest;
  logic [XLEN-1:0] mem_wb_data;

  logic [XLEN-1:0] regs [NREG];

  // ---------------- ID: decode ----------------
  logic [5:0]      op, funct;
  logic [RW-1:0]   id_rs, id_rt, id_rd, id_dest;
  logic [XLEN-1:0] id_imm, id_a, id_b;
  logic            dec_reg_write, dec_mem_read, dec_mem_write, dec_branch, dec_jump;
  logic            dec_use_imm, uses_rs, uses_rt;
  alu_op_e         dec_alu_op;
  logic            wb_we;

  assign op     = if_id_instr[31:26];
  assign funct  = if_id_instr[5:0];
  assign id_rs  = if_id_instr[21 +: RW];
  assign id_rt  = if_id_instr[16 +: RW];
  assign id_rd  = if_id_instr[11 +: RW];
  assign id_imm = {{(XLEN-16){if_id_instr[15]}}, if_id_instr[15:0]};

  always_comb begin
    dec_reg_write = 1'b0;
    dec_mem_read  = 1'b0;
    dec_mem_write = 1'b0;
    dec_branch    = 1'b0;
    dec_jump      = 1'b0;
    dec_use_imm   = 1'b0;
    uses_rs       = 1'b0;
    uses_rt       = 1'b0;
    dec_alu_op    = ALU_ADD;
    id_dest       = id_rt;
    case (op)
      6'h00: begin
        id_dest       = id_rd;
        dec_reg_write = 1'b1;
        uses_rs       = 1'b1;
        uses_rt       = 1'b1;
        case (funct)
          6'h20:   dec_alu_op = ALU_ADD;
          6'h22:   dec_alu_op = ALU_SUB;
          6'h24:   dec_alu_op = ALU_AND;
          6'h25:   dec_alu_op = ALU_OR;
          6'h2A:   dec_alu_op = ALU_SLT;
          6'h00: begin
            dec_alu_op = ALU_SLL;
            uses_rs    = 1'b0;
          end
          default: begin
            dec_reg_write = 1'b0;
            uses_rs       = 1'b0;
            uses_rt       = 1'b0;
          end
        endcase
      end
      6'h08: begin
        dec_reg_write = 1'b1;
        dec_use_imm   = 1'b1;
        uses_rs       = 1'b1;
      end
      6'h23: begin
        dec_reg_write = 1'b1;
        dec_mem_read  = 1'b1;
        dec_use_imm   = 1'b1;
        uses_rs       = 1'b1;
      end
      6'h2B: begin
        dec_mem_write = 1'b1;
        dec_use_imm   = 1'b1;
        uses_rs       = 1'b1;
        uses_rt       = 1'b1;
      end
      6'h04: begin
        dec_branch = 1'b1;
        uses_rs    = 1'b1;
        uses_rt    = 1'b1;
      end
      6'h02:   dec_jump = 1'b1;
      default: ;
    endcase
  end

  // Register read with write-through from the WB stage.
  assign wb_we = mem_wb_valid && mem_wb_reg_write && (mem_wb_dest != '0);
  assign id_a  = (wb_we && mem_wb_dest == id_rs) ? mem_wb_data : regs[id_rs];
  assign id_b  = (wb_we && mem_wb_dest == id_rt) ? mem_wb_data : regs[id_rt];

  // ---------------- Hazard detection ----------------
  logic ex_hit_rs, ex_hit_rt, mem_hit_rs, mem_hit_rt, load_use, raw, hazard;

  always_comb begin
    ex_hit_rs  = id_ex_valid && id_ex_reg_write && (id_ex_dest != '0) && (id_ex_dest == id_rs);
    ex_hit_rt  = id_ex_valid && id_ex_reg_write && (id_ex_dest != '0) && (id_ex_dest == id_rt);
    mem_hit_rs = ex_mem_valid && ex_mem_reg_write && (ex_mem_dest != '0) && (ex_mem_dest == id_rs);
    mem_hit_rt = ex_mem_valid && ex_mem_reg_write && (ex_mem_dest != '0) && (ex_mem_dest == id_rt);
    load_use   = id_ex_mem_read && ((uses_rs && ex_hit_rs) || (uses_rt && ex_hit_rt));
    raw        = (uses_rs && (ex_hit_rs || mem_hit_rs)) || (uses_rt && (ex_hit_rt || mem_hit_rt));
    hazard     = if_id_valid && ((FORWARD != 0) ? load_use : raw);
  end

  // ---------------- EX: forwarding, ALU, branch ----------------
  logic [XLEN-1:0] ex_a, ex_b, alu_b, alu_res, br_target;
  logic            br_taken;

  always_comb begin
    ex_a = id_ex_a;
    ex_b = id_ex_b;
    if (FORWARD != 0) begin
      // A load result is not available in EX/MEM; load-use stall guarantees it is never needed there.
      if (ex_mem_valid && ex_mem_reg_write && !ex_mem_mem_read &&
          ex_mem_dest != '0 && ex_mem_dest == id_ex_rs)
        ex_a = ex_mem_alu;
      else if (wb_we && mem_wb_dest == id_ex_rs)
        ex_a = mem_wb_data;
      if (ex_mem_valid && ex_mem_reg_write && !ex_mem_mem_read &&
          ex_mem_dest != '0 && ex_mem_dest == id_ex_rt)
        ex_b = ex_mem_alu;
      else if (wb_we && mem_wb_dest == id_ex_rt)
        ex_b = mem_wb_data;
    end
  end

  assign alu_b = id_ex_use_imm ? id_ex_imm : ex_b;

  always_comb begin
    alu_res = '0;
    case (id_ex_alu_op)
      ALU_ADD: alu_res = ex_a + alu_b;
      ALU_SUB: alu_res = ex_a - alu_b;
      ALU_AND: alu_res = ex_a & alu_b;
      ALU_OR:  alu_res = ex_a | alu_b;
      ALU_SLT: alu_res = {{(XLEN-1){1'b0}}, ($signed(ex_a) < $signed(alu_b))};
      ALU_SLL: alu_res = ex_b << id_ex_shamt;
      default: alu_res = ex_a + alu_b;
    endcase
  end

  assign br_taken  = id_ex_valid && id_ex_branch && (ex_a == ex_b);
  assign br_target = id_ex_pc4 + (id_ex_imm << 2);

  // ---------------- Control priority ----------------
  logic [XLEN-1:0] pc4, jump_target;
  logic            jump_taken;

  assign pc4         = pc + XLEN'(4);
  assign jump_target = {if_id_pc4[XLEN-1:28], if_id_instr[25:0], 2'b00};
  assign stall       = hazard && !br_taken;
  assign jump_taken  = if_id_valid && dec_jump && !hazard && !br_taken;
  assign flush       = br_taken || jump_taken;

  // ---------------- Pipeline registers ----------------
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pc               <= RESET_PC;
      if_id_valid      <= 1'b0;
      if_id_instr      <= '0;
      if_id_pc4        <= '0;
      id_ex_valid      <= 1'b0;
      id_ex_reg_write  <= 1'b0;
      id_ex_mem_read   <= 1'b0;
      id_ex_mem_write  <= 1'b0;
      id_ex_branch     <= 1'b0;
      id_ex_use_imm    <= 1'b0;
      id_ex_alu_op     <= ALU_ADD;
      id_ex_rs         <= '0;
      id_ex_rt         <= '0;
      id_ex_dest       <= '0;
      id_ex_a          <= '0;
      id_ex_b          <= '0;
      id_ex_imm        <= '0;
      id_ex_pc4        <= '0;
      id_ex_shamt      <= '0;
      ex_mem_valid     <= 1'b0;
      ex_mem_reg_write <= 1'b0;
      ex_mem_mem_read  <= 1'b0;
      ex_mem_mem_write <= 1'b0;
      ex_mem_dest      <= '0;
      ex_mem_alu       <= '0;
      ex_mem_store     <= '0;
      mem_wb_valid     <= 1'b0;
      mem_wb_reg_write <= 1'b0;
      mem_wb_dest      <= '0;
      mem_wb_data      <= '0;
    end else begin
      if (br_taken) begin
        pc          <= br_target;
        if_id_valid <= 1'b0;
      end else if (stall) begin
        pc <= pc;
      end else if (jump_taken) begin
        pc          <= jump_target;
        if_id_valid <= 1'b0;
      end else begin
        pc          <= pc4;
        if_id_valid <= 1'b1;
        if_id_instr <= imem_rdata;
        if_id_pc4   <= pc4;
      end

      id_ex_valid     <= if_id_valid && !br_taken && !stall;
      id_ex_reg_write <= dec_reg_write;
      id_ex_mem_read  <= dec_mem_read;
      id_ex_mem_write <= dec_mem_write;
      id_ex_branch    <= dec_branch;
      id_ex_use_imm   <= dec_use_imm;
      id_ex_alu_op    <= dec_alu_op;
      id_ex_rs        <= id_rs;
      id_ex_rt        <= id_rt;
      id_ex_dest      <= id_dest;
      id_ex_a         <= id_a;
      id_ex_b         <= id_b;
      id_ex_imm       <= id_imm;
      id_ex_pc4       <= if_id_pc4;
      id_ex_shamt     <= if_id_instr[10:6];

      ex_mem_valid     <= id_ex_valid;
      ex_mem_reg_write <= id_ex_reg_write;
      ex_mem_mem_read  <= id_ex_mem_read;
      ex_mem_mem_write <= id_ex_mem_write;
      ex_mem_dest      <= id_ex_dest;
      ex_mem_alu       <= alu_res;
      ex_mem_store     <= ex_b;

      mem_wb_valid     <= ex_mem_valid;
      mem_wb_reg_write <= ex_mem_reg_write;
      mem_wb_dest      <= ex_mem_dest;
      mem_wb_data      <= ex_mem_mem_read ? dmem_rdata : ex_mem_alu;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int unsigned i = 0; i < NREG; i++) regs[i] <= '0;
    end else if (wb_we) begin
      regs[mem_wb_dest] <= mem_wb_data;
    end
  end

  // ---------------- Outputs ----------------
  assign imem_addr  = pc;
  assign dmem_addr  = ex_mem_alu;
  assign dmem_wdata = ex_mem_store;
  assign dmem_we    = ex_mem_valid && ex_mem_mem_write;
  assign dmem_re    = ex_mem_valid && ex_mem_mem_read;
  assign wb_valid   = wb_we;
  assign wb_data    = wb_we ? mem_wb_data : '0;

  always_comb begin
    wb_rd = '0;
    if (wb_we) wb_rd[RW-1:0] = mem_wb_dest;
  end

endmodule

// File: tb/tb_pipelined_cpu_hz.sv
// Directed bench for pipelined_cpu_hz: three instances (forwarding, interlock-only, 64-bit)
// run the same programs; retirements, stall/flush cycles and memory strobes are checked.
module tb_pipelined_cpu_hz;
  logic clk = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  logic [31:0] f1_imem_addr, f1_dmem_addr, f1_dmem_wdata, f1_dmem_rdata, f1_wb_data;
  logic [31:0] f0_imem_addr, f0_dmem_addr, f0_dmem_wdata, f0_dmem_rdata, f0_wb_data;
  logic [63:0] w_imem_addr, w_dmem_addr, w_dmem_wdata, w_dmem_rdata, w_wb_data;
  logic [31:0] f1_imem_rdata, f0_imem_rdata, w_imem_rdata;
  logic        f1_dmem_we, f1_dmem_re, f1_wb_valid, f1_stall, f1_flush;
  logic        f0_dmem_we, f0_dmem_re, f0_wb_valid, f0_stall, f0_flush;
  logic        w_dmem_we, w_dmem_re, w_wb_valid, w_stall, w_flush;
  logic [4:0]  f1_wb_rd, f0_wb_rd, w_wb_rd;

  pipelined_cpu_hz #(.XLEN(32), .NREG(32), .FORWARD(1), .RESET_PC(32'h0)) u_f1 (
    .clk(clk), .reset(reset), .imem_addr(f1_imem_addr), .imem_rdata(f1_imem_rdata),
    .dmem_addr(f1_dmem_addr), .dmem_wdata(f1_dmem_wdata), .dmem_we(f1_dmem_we),
    .dmem_re(f1_dmem_re), .dmem_rdata(f1_dmem_rdata), .wb_valid(f1_wb_valid),
    .wb_rd(f1_wb_rd), .wb_data(f1_wb_data), .stall(f1_stall), .flush(f1_flush));

  pipelined_cpu_hz #(.XLEN(32), .NREG(32), .FORWARD(0), .RESET_PC(32'h0)) u_f0 (
    .clk(clk), .reset(reset), .imem_addr(f0_imem_addr), .imem_rdata(f0_imem_rdata),
    .dmem_addr(f0_dmem_addr), .dmem_wdata(f0_dmem_wdata), .dmem_we(f0_dmem_we),
    .dmem_re(f0_dmem_re), .dmem_rdata(f0_dmem_rdata), .wb_valid(f0_wb_valid),
    .wb_rd(f0_wb_rd), .wb_data(f0_wb_data), .stall(f0_stall), .flush(f0_flush));

  pipelined_cpu_hz #(.XLEN(64), .NREG(32), .FORWARD(1), .RESET_PC(64'h0)) u_w (
    .clk(clk), .reset(reset), .imem_addr(w_imem_addr), .imem_rdata(w_imem_rdata),
    .dmem_addr(w_dmem_addr), .dmem_wdata(w_dmem_wdata), .dmem_we(w_dmem_we),
    .dmem_re(w_dmem_re), .dmem_rdata(w_dmem_rdata), .wb_valid(w_wb_valid),
    .wb_rd(w_wb_rd), .wb_data(w_wb_data), .stall(w_stall), .flush(w_flush));

  // Memories: shared program ROM, private data RAMs (word 0 preset to 0x11 during reset).
  logic [31:0] imem [64];
  logic [31:0] dm1 [64];
  logic [31:0] dm0 [64];
  logic [63:0] dmw [64];
  int unsigned w_stores = 0;

  assign f1_imem_rdata = imem[f1_imem_addr[7:2]];
  assign f0_imem_rdata = imem[f0_imem_addr[7:2]];
  assign w_imem_rdata  = imem[w_imem_addr[7:2]];
  assign f1_dmem_rdata = dm1[f1_dmem_addr[7:2]];
  assign f0_dmem_rdata = dm0[f0_dmem_addr[7:2]];
  assign w_dmem_rdata  = dmw[w_dmem_addr[7:2]];

  always @(posedge clk) begin
    if (!reset) begin
      for (int i = 0; i < 64; i++) begin
        dm1[i] <= (i == 0) ? 32'h11 : 32'h0;
        dm0[i] <= (i == 0) ? 32'h11 : 32'h0;
        dmw[i] <= (i == 0) ? 64'h11 : 64'h0;
      end
    end else begin
      if (f1_dmem_we) dm1[f1_dmem_addr[7:2]] <= f1_dmem_wdata;
      if (f0_dmem_we) dm0[f0_dmem_addr[7:2]] <= f0_dmem_wdata;
      if (w_dmem_we)  dmw[w_dmem_addr[7:2]]  <= w_dmem_wdata;
    end
    if (w_dmem_we) w_stores <= w_stores + 1;
  end

  // Retirement log and stall/flush counters.
  typedef struct packed {
    int unsigned dut;
    logic [4:0]  rd;
    logic [63:0] data;
    int unsigned cyc;
  } ret_t;

  ret_t        ret_q [$];
  int unsigned cyc = 0;
  int unsigned f1_stalls = 0, f1_flushes = 0, f0_stalls = 0;

  function automatic ret_t mk(input int unsigned dut, input logic [4:0] rd,
                              input logic [63:0] data, input int unsigned c);
    ret_t e;
    e.dut = dut; e.rd = rd; e.data = data; e.cyc = c;
    return e;
  endfunction

  always @(posedge clk) cyc <= reset ? cyc + 1 : 0;

  always @(negedge clk) begin
    if (reset) begin
      if (f1_wb_valid) ret_q.push_back(mk(0, f1_wb_rd, {32'h0, f1_wb_data}, cyc));
      if (f0_wb_valid) ret_q.push_back(mk(1, f0_wb_rd, {32'h0, f0_wb_data}, cyc));
      if (w_wb_valid)  ret_q.push_back(mk(2, w_wb_rd, w_wb_data, cyc));
      if (f1_stall)  f1_stalls  <= f1_stalls + 1;
      if (f1_flush)  f1_flushes <= f1_flushes + 1;
      if (f0_stall)  f0_stalls  <= f0_stalls + 1;
    end
  end

  // Instruction encoders.
  function automatic logic [31:0] rtype(input logic [5:0] funct, input logic [4:0] rd,
                                        input logic [4:0] rs, input logic [4:0] rt,
                                        input logic [4:0] sh);
    return {6'h00, rs, rt, rd, sh, funct};
  endfunction

  function automatic logic [31:0] itype(input logic [5:0] op, input logic [4:0] rt,
                                        input logic [4:0] rs, input logic [15:0] imm);
    return {op, rs, rt, imm};
  endfunction

  typedef logic [23:0][31:0] prog_t;

  typedef struct packed {
    prog_t             prog;
    int unsigned       n_ret;
    logic [9:0][4:0]   rd;
    logic [9:0][63:0]  data;
    int unsigned       stalls;
    int unsigned       flushes;
    int unsigned       first_cyc;
  } vec_t;

  int unsigned n_cmp = 0;
  int unsigned n_bad = 0;

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, got, exp);
    end
  endtask

  task automatic check_retire(input string name, input int unsigned dut, input int unsigned base,
                              input int unsigned n, input logic [9:0][4:0] erd,
                              input logic [9:0][63:0] edat, input int unsigned first_cyc);
    int unsigned k = 0;
    for (int unsigned i = base; i < ret_q.size(); i++) begin
      if (ret_q[i].dut == dut) begin
        if (k < n) begin
          check($sformatf("%s rd[%0d]", name, k), {59'h0, ret_q[i].rd}, {59'h0, erd[k]});
          check($sformatf("%s data[%0d]", name, k), ret_q[i].data, edat[k]);
          if (k == 0 && first_cyc != 0)
            check($sformatf("%s latency", name), 64'(ret_q[i].cyc), 64'(first_cyc));
        end
        k++;
      end
    end
    check($sformatf("%s retire count", name), 64'(k), 64'(n));
  endtask

  task automatic start_prog(input prog_t p);
    reset = 1'b0;
    repeat (2) @(posedge clk);
    for (int i = 0; i < 64; i++) imem[i] = (i < 24) ? p[i] : 32'h0;
    @(negedge clk);
    reset = 1'b1;
  endtask

  localparam int NV = 5;
  vec_t  vecs [NV];
  string names [NV] = '{"add_chain", "load_use", "beq_taken", "jump", "mix"};

  initial begin
    int unsigned base, s1, fl1, s0, st;
    bit          found;
    prog_t       p;
    logic [9:0][4:0]  erd;
    logic [9:0][63:0] edat;

    for (int v = 0; v < NV; v++) vecs[v] = '0;

    // addi r1,r0,5; add r2,r1,r1; sub r3,r2,r1
    vecs[0].prog[0] = itype(6'h08, 5'd1, 5'd0, 16'd5);
    vecs[0].prog[1] = rtype(6'h20, 5'd2, 5'd1, 5'd1, 5'd0);
    vecs[0].prog[2] = rtype(6'h22, 5'd3, 5'd2, 5'd1, 5'd0);
    vecs[0].n_ret = 3; vecs[0].first_cyc = 4;
    vecs[0].rd[0] = 5'd1; vecs[0].data[0] = 64'd5;
    vecs[0].rd[1] = 5'd2; vecs[0].data[1] = 64'd10;
    vecs[0].rd[2] = 5'd3; vecs[0].data[2] = 64'd5;

    // lw r4,0(r0); add r5,r4,r4
    vecs[1].prog[0] = itype(6'h23, 5'd4, 5'd0, 16'd0);
    vecs[1].prog[1] = rtype(6'h20, 5'd5, 5'd4, 5'd4, 5'd0);
    vecs[1].n_ret = 2; vecs[1].stalls = 1;
    vecs[1].rd[0] = 5'd4; vecs[1].data[0] = 64'h11;
    vecs[1].rd[1] = 5'd5; vecs[1].data[1] = 64'h22;

    // beq r0,r0,+2 skips two addi; target addi r9
    vecs[2].prog[0] = itype(6'h04, 5'd0, 5'd0, 16'd2);
    vecs[2].prog[1] = itype(6'h08, 5'd7, 5'd0, 16'd1);
    vecs[2].prog[2] = itype(6'h08, 5'd8, 5'd0, 16'd2);
    vecs[2].prog[3] = itype(6'h08, 5'd9, 5'd0, 16'd3);
    vecs[2].n_ret = 1; vecs[2].flushes = 1;
    vecs[2].rd[0] = 5'd9; vecs[2].data[0] = 64'd3;

    // j 0x40; addi r10 (squashed); addi r6,r0,6 at 0x40
    vecs[3].prog[0]  = {6'h02, 26'h10};
    vecs[3].prog[1]  = itype(6'h08, 5'd10, 5'd0, 16'd9);
    vecs[3].prog[16] = itype(6'h08, 5'd6, 5'd0, 16'd6);
    vecs[3].n_ret = 1; vecs[3].flushes = 1;
    vecs[3].rd[0] = 5'd6; vecs[3].data[0] = 64'd6;

    // forwarding priority, sw/lw, load-use on sll, remaining ALU ops, unknown op, r0 write
    vecs[4].prog[0]  = itype(6'h08, 5'd1, 5'd0, 16'd3);
    vecs[4].prog[1]  = itype(6'h08, 5'd1, 5'd0, 16'd4);
    vecs[4].prog[2]  = rtype(6'h20, 5'd2, 5'd1, 5'd1, 5'd0);
    vecs[4].prog[3]  = itype(6'h2B, 5'd2, 5'd0, 16'd8);
    vecs[4].prog[4]  = itype(6'h23, 5'd3, 5'd0, 16'd8);
    vecs[4].prog[5]  = rtype(6'h00, 5'd4, 5'd0, 5'd3, 5'd2);
    vecs[4].prog[6]  = rtype(6'h22, 5'd5, 5'd0, 5'd4, 5'd0);
    vecs[4].prog[7]  = rtype(6'h2A, 5'd6, 5'd5, 5'd0, 5'd0);
    vecs[4].prog[8]  = rtype(6'h24, 5'd7, 5'd5, 5'd4, 5'd0);
    vecs[4].prog[9]  = rtype(6'h25, 5'd8, 5'd5, 5'd6, 5'd0);
    vecs[4].prog[10] = 32'hFC00_0000;
    vecs[4].prog[11] = itype(6'h08, 5'd0, 5'd0, 16'd7);
    vecs[4].prog[12] = rtype(6'h20, 5'd9, 5'd0, 5'd0, 5'd0);
    vecs[4].n_ret = 10; vecs[4].stalls = 1;
    vecs[4].rd[0] = 5'd1; vecs[4].data[0] = 64'd3;
    vecs[4].rd[1] = 5'd1; vecs[4].data[1] = 64'd4;
    vecs[4].rd[2] = 5'd2; vecs[4].data[2] = 64'd8;
    vecs[4].rd[3] = 5'd3; vecs[4].data[3] = 64'd8;
    vecs[4].rd[4] = 5'd4; vecs[4].data[4] = 64'h20;
    vecs[4].rd[5] = 5'd5; vecs[4].data[5] = 64'hFFFF_FFE0;
    vecs[4].rd[6] = 5'd6; vecs[4].data[6] = 64'd1;
    vecs[4].rd[7] = 5'd7; vecs[4].data[7] = 64'h20;
    vecs[4].rd[8] = 5'd8; vecs[4].data[8] = 64'hFFFF_FFE1;
    vecs[4].rd[9] = 5'd9; vecs[4].data[9] = 64'd0;

    for (int v = 0; v < NV; v++) begin
      start_prog(vecs[v].prog);
      base = ret_q.size(); s1 = f1_stalls; fl1 = f1_flushes;
      repeat (40) @(negedge clk);
      #1;
      check_retire(names[v], 0, base, vecs[v].n_ret, vecs[v].rd, vecs[v].data, vecs[v].first_cyc);
      check({names[v], " stalls"}, 64'(f1_stalls - s1), 64'(vecs[v].stalls));
      check({names[v], " flushes"}, 64'(f1_flushes - fl1), 64'(vecs[v].flushes));
      if (v == 4) check("mix stored word", {32'h0, dm1[2]}, 64'd8);
    end

    // Interlock-only core: two stalls per dependent instruction, r0 stays zero.
    p = vecs[0].prog;
    p[3] = itype(6'h08, 5'd0, 5'd0, 16'd7);
    p[4] = rtype(6'h20, 5'd11, 5'd0, 5'd0, 5'd0);
    start_prog(p);
    base = ret_q.size(); s0 = f0_stalls;
    repeat (40) @(negedge clk);
    #1;
    erd = '0; edat = '0;
    erd[0] = 5'd1;  edat[0] = 64'd5;
    erd[1] = 5'd2;  edat[1] = 64'd10;
    erd[2] = 5'd3;  edat[2] = 64'd5;
    erd[3] = 5'd11; edat[3] = 64'd0;
    check_retire("nofwd", 1, base, 4, erd, edat, 0);
    check("nofwd stalls", 64'(f0_stalls - s0), 64'd4);

    // 64-bit sign extension and wrap.
    p = '0;
    p[0] = itype(6'h08, 5'd1, 5'd0, 16'hFFFF);
    p[1] = rtype(6'h20, 5'd2, 5'd1, 5'd1, 5'd0);
    start_prog(p);
    base = ret_q.size();
    repeat (15) @(negedge clk);
    #1;
    erd = '0; edat = '0;
    erd[0] = 5'd1; edat[0] = 64'hFFFF_FFFF_FFFF_FFFF;
    erd[1] = 5'd2; edat[1] = 64'hFFFF_FFFF_FFFF_FFFE;
    check_retire("xlen64", 2, base, 2, erd, edat, 0);

    // Reset pulled low while a store is in MEM.
    p = '0;
    p[0] = itype(6'h08, 5'd2, 5'd0, 16'd5);
    p[1] = itype(6'h2B, 5'd2, 5'd0, 16'd16);
    start_prog(p);
    found = 1'b0;
    for (int c = 0; c < 20 && !found; c++) begin
      @(negedge clk);
      if (w_dmem_we) found = 1'b1;
    end
    check("midrst sw strobe seen", {63'h0, found}, 64'd1);
    if (found) begin
      check("midrst sw addr", w_dmem_addr, 64'd16);
      check("midrst sw data", w_dmem_wdata, 64'd5);
      st = w_stores;
      reset = 1'b0;
      #1;
      check("rst dmem_we",    {63'h0, w_dmem_we}, 64'd0);
      check("rst dmem_re",    {63'h0, w_dmem_re}, 64'd0);
      check("rst dmem_addr",  w_dmem_addr, 64'd0);
      check("rst dmem_wdata", w_dmem_wdata, 64'd0);
      check("rst imem_addr",  w_imem_addr, 64'd0);
      check("rst wb_valid",   {63'h0, w_wb_valid}, 64'd0);
      check("rst wb_data",    w_wb_data, 64'd0);
      check("rst stall_flush", {62'h0, w_stall, w_flush}, 64'd0);
      @(posedge clk);
      #1;
      check("rst no store completes", 64'(w_stores), 64'(st));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
